// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one CORDIC engine among NREQ requesters.
// Latches the winner's operands, launches the engine, and routes the result or a timeout back.
module cordic_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned W       = 24,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   req_x,
  input  logic [NREQ*W-1:0]   req_y,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [W-1:0]        rsp_angle,
  output logic [W-1:0]        rsp_magnitude,
  output logic                err_timeout,
  output logic                busy,
  output logic [W-1:0]        crd_x,
  output logic [W-1:0]        crd_y,
  output logic                crd_start,
  input  logic                crd_done,
  input  logic [W-1:0]        crd_angle,
  input  logic [W-1:0]        crd_magnitude
);

  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DELIVER
  } state_t;

  state_t          state, state_n;
  logic [OW-1:0]   owner, owner_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [OW-1:0]   win;
  logic            win_found;
  logic [NREQ-1:0] gnt_n, rsp_valid_n;
  logic [W-1:0]    crd_x_n, crd_y_n, rsp_angle_n, rsp_magnitude_n;
  logic            crd_start_n, err_timeout_n, busy_n;

  // Round-robin search starting just after the last owner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!win_found && req[OW'((32'(owner) + k) % NREQ)]) begin
        win_found = 1'b1;
        win       = OW'((32'(owner) + k) % NREQ);
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n         = state;
    owner_n         = owner;
    cnt_n           = cnt;
    crd_x_n         = crd_x;
    crd_y_n         = crd_y;
    rsp_angle_n     = rsp_angle;
    rsp_magnitude_n = rsp_magnitude;
    gnt_n           = '0;
    rsp_valid_n     = '0;
    crd_start_n     = 1'b0;
    err_timeout_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (win_found) begin
          state_n     = ST_LAUNCH;
          owner_n     = win;
          crd_x_n     = req_x[32'(win) * W +: W];
          crd_y_n     = req_y[32'(win) * W +: W];
          gnt_n       = NREQ'(1) << win;
          crd_start_n = 1'b1;
          cnt_n       = '0;
        end
      end
      ST_LAUNCH: begin
        state_n = ST_WAIT;
        cnt_n   = cnt + CW'(1);
      end
      ST_WAIT: begin
        // A done arriving on the timeout edge still counts as a completion.
        if (crd_done) begin
          state_n         = ST_DELIVER;
          rsp_angle_n     = crd_angle;
          rsp_magnitude_n = crd_magnitude;
          rsp_valid_n     = NREQ'(1) << owner;
        end else if (cnt >= CW'(TIMEOUT - 1)) begin
          state_n       = ST_IDLE;
          err_timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_DELIVER: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      owner         <= OW'(NREQ - 1);
      cnt           <= '0;
      crd_x         <= '0;
      crd_y         <= '0;
      rsp_angle     <= '0;
      rsp_magnitude <= '0;
      gnt           <= '0;
      rsp_valid     <= '0;
      crd_start     <= 1'b0;
      err_timeout   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      owner         <= owner_n;
      cnt           <= cnt_n;
      crd_x         <= crd_x_n;
      crd_y         <= crd_y_n;
      rsp_angle     <= rsp_angle_n;
      rsp_magnitude <= rsp_magnitude_n;
      gnt           <= gnt_n;
      rsp_valid     <= rsp_valid_n;
      crd_start     <= crd_start_n;
      err_timeout   <= err_timeout_n;
      busy          <= busy_n;
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a fixed-latency engine model (angle=x+y, magnitude=x-y).
module tb_cordic_arbiter;

  localparam int unsigned NREQ    = 3;
  localparam int unsigned W       = 24;
  localparam int unsigned TIMEOUT = 64;
  localparam logic [W-1:0] JUNK   = 24'h5A5A5A;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_x, req_y;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [W-1:0]      rsp_angle, rsp_magnitude;
  logic              err_timeout, busy;
  logic [W-1:0]      crd_x, crd_y;
  logic              crd_start;
  logic              crd_done;
  logic [W-1:0]      crd_angle, crd_magnitude;

  logic              eng_done, stray_done, eng_en;
  int                eng_lat, eng_rem;
  logic [W-1:0]      eng_x, eng_y;

  int n_checks = 0;
  int n_errors = 0;

  assign crd_done = eng_done | stray_done;

  cordic_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_x         (req_x),
    .req_y         (req_y),
    .gnt           (gnt),
    .rsp_valid     (rsp_valid),
    .rsp_angle     (rsp_angle),
    .rsp_magnitude (rsp_magnitude),
    .err_timeout   (err_timeout),
    .busy          (busy),
    .crd_x         (crd_x),
    .crd_y         (crd_y),
    .crd_start     (crd_start),
    .crd_done      (crd_done),
    .crd_angle     (crd_angle),
    .crd_magnitude (crd_magnitude)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Engine model: done pulses eng_lat cycles after the start cycle; results are junk otherwise.
  initial begin
    eng_done = 1'b0; eng_rem = 0; eng_x = '0; eng_y = '0;
    crd_angle = JUNK; crd_magnitude = JUNK;
    forever begin
      @(negedge clk);
      eng_done = 1'b0; crd_angle = JUNK; crd_magnitude = JUNK;
      if (eng_rem > 0) begin
        eng_rem--;
        if (eng_rem == 0) begin
          eng_done      = 1'b1;
          crd_angle     = eng_x + eng_y;
          crd_magnitude = eng_x - eng_y;
        end
      end
      if (crd_start && eng_en) begin
        eng_x = crd_x; eng_y = crd_y; eng_rem = eng_lat;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // sel 0: gnt, 1: rsp_valid, 2: err_timeout. n = cycles waited, -1 if the bound expired.
  task automatic wait_evt(input int sel, input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim && n < 0; i++) begin
      @(negedge clk);
      if ((sel == 0 && gnt != '0) || (sel == 1 && rsp_valid != '0) || (sel == 2 && err_timeout))
        n = i;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (gnt !== 3'b000) begin n_errors++; $display("FAIL reset_gnt got %b want 000", gnt); end
    n_checks++; if (rsp_valid !== 3'b000) begin n_errors++; $display("FAIL reset_rsp_valid got %b want 000", rsp_valid); end
    n_checks++; if ({crd_start, err_timeout, busy} !== 3'b000) begin n_errors++; $display("FAIL reset_flags got %b want 000", {crd_start, err_timeout, busy}); end
    n_checks++; if ({crd_x, crd_y} !== '0) begin n_errors++; $display("FAIL reset_operands got %h want 0", {crd_x, crd_y}); end
    n_checks++; if ({rsp_angle, rsp_magnitude} !== '0) begin n_errors++; $display("FAIL reset_results got %h want 0", {rsp_angle, rsp_magnitude}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n;
    eng_lat = 20; eng_en = 1'b1;
    req_x = '0; req_y = '0;
    req_x[W-1:0] = W'(10000); req_y[W-1:0] = W'(10000);
    req = 3'b001;
    wait_evt(0, 5, n);
    n_checks++; if (n !== 1) begin n_errors++; $display("FAIL single_gnt_latency got %0d want 1", n); end
    n_checks++; if ({gnt, crd_start, busy} !== 5'b00111) begin n_errors++; $display("FAIL single_gnt_start got %b want 00111", {gnt, crd_start, busy}); end
    n_checks++; if (crd_x !== W'(10000) || crd_y !== W'(10000)) begin n_errors++; $display("FAIL single_operands got %0d,%0d want 10000,10000", crd_x, crd_y); end
    req = '0;
    @(negedge clk);
    n_checks++; if ({gnt, crd_start} !== 4'b0000) begin n_errors++; $display("FAIL single_gnt_one_cycle got %b want 0000", {gnt, crd_start}); end
    wait_evt(1, 40, n);
    n_checks++; if (n !== 20) begin n_errors++; $display("FAIL single_rsp_latency got %0d want 20", n); end
    n_checks++; if (rsp_valid !== 3'b001) begin n_errors++; $display("FAIL single_rsp_valid got %b want 001", rsp_valid); end
    n_checks++; if (rsp_angle !== W'(20000) || rsp_magnitude !== W'(0)) begin n_errors++; $display("FAIL single_result got %0d,%0d want 20000,0", rsp_angle, rsp_magnitude); end
    @(negedge clk);
    n_checks++; if ({rsp_valid, busy} !== 4'b0000) begin n_errors++; $display("FAIL single_after got %b want 0000", {rsp_valid, busy}); end
    n_checks++; if (rsp_angle !== W'(20000)) begin n_errors++; $display("FAIL single_hold got %0d want 20000", rsp_angle); end
  endtask

  task automatic test_contention();
    int n;
    logic [W-1:0] xs [3];
    logic [W-1:0] ys [3];
    logic [W-1:0] exp_ang [3];
    logic [W-1:0] exp_mag [3];
    logic [NREQ-1:0] oh;
    xs[0] = W'(10000);  ys[0] = W'(10000);  exp_ang[0] = W'(20000); exp_mag[0] = W'(0);
    xs[1] = W'(-10000); ys[1] = W'(10000);  exp_ang[1] = W'(0);     exp_mag[1] = W'(-20000);
    xs[2] = W'(10000);  ys[2] = W'(-10000); exp_ang[2] = W'(0);     exp_mag[2] = W'(20000);
    eng_lat = 3;
    for (int i = 0; i < 3; i++) begin
      req_x[i*W +: W] = xs[i]; req_y[i*W +: W] = ys[i];
    end
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      oh = NREQ'(1) << i;
      wait_evt(0, 6, n);
      n_checks++; if (n !== ((i == 0) ? 1 : 2)) begin n_errors++; $display("FAIL contention_gap%0d got %0d want %0d", i, n, (i == 0) ? 1 : 2); end
      n_checks++; if (gnt !== oh) begin n_errors++; $display("FAIL contention_gnt%0d got %b want %b", i, gnt, oh); end
      n_checks++; if (crd_x !== xs[i] || crd_y !== ys[i]) begin n_errors++; $display("FAIL contention_ops%0d got %h,%h want %h,%h", i, crd_x, crd_y, xs[i], ys[i]); end
      req[i] = 1'b0;
      wait_evt(1, 10, n);
      n_checks++; if (n !== 4 || rsp_valid !== oh) begin n_errors++; $display("FAIL contention_rsp%0d got n=%0d valid=%b want n=4 valid=%b", i, n, rsp_valid, oh); end
      n_checks++; if (rsp_angle !== exp_ang[i] || rsp_magnitude !== exp_mag[i]) begin n_errors++; $display("FAIL contention_result%0d got %h,%h want %h,%h", i, rsp_angle, rsp_magnitude, exp_ang[i], exp_mag[i]); end
    end
  endtask

  task automatic test_fairness();
    int n;
    do_reset();
    eng_lat = 3;
    req = 3'b010;
    wait_evt(0, 5, n);
    n_checks++; if (gnt !== 3'b010) begin n_errors++; $display("FAIL fair_first got %b want 010", gnt); end
    req = '0;
    wait_evt(1, 10, n);
    @(negedge clk);
    req = 3'b011;
    wait_evt(0, 5, n);
    n_checks++; if (n !== 1 || gnt !== 3'b001) begin n_errors++; $display("FAIL fair_skip got n=%0d gnt=%b want n=1 gnt=001", n, gnt); end
    req = 3'b010;
    wait_evt(1, 10, n);
    n_checks++; if (rsp_valid !== 3'b001) begin n_errors++; $display("FAIL fair_rsp0 got %b want 001", rsp_valid); end
    wait_evt(0, 5, n);
    n_checks++; if (n !== 2 || gnt !== 3'b010) begin n_errors++; $display("FAIL fair_next got n=%0d gnt=%b want n=2 gnt=010", n, gnt); end
    req = '0;
    wait_evt(1, 10, n);
    n_checks++; if (rsp_valid !== 3'b010) begin n_errors++; $display("FAIL fair_rsp1 got %b want 010", rsp_valid); end
  endtask

  task automatic test_timeout();
    int n, rv;
    eng_en = 1'b0;
    req = 3'b001;
    wait_evt(0, 5, n);
    n_checks++; if (gnt !== 3'b001) begin n_errors++; $display("FAIL timeout_gnt got %b want 001", gnt); end
    req = '0;
    n = -1; rv = 0;
    for (int i = 1; i <= 100 && n < 0; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) rv++;
      if (err_timeout) n = i;
    end
    n_checks++; if (n !== 64) begin n_errors++; $display("FAIL timeout_latency got %0d want 64", n); end
    n_checks++; if (rv !== 0) begin n_errors++; $display("FAIL timeout_no_rsp got %0d want 0", rv); end
    @(negedge clk);
    n_checks++; if ({err_timeout, busy} !== 2'b00) begin n_errors++; $display("FAIL timeout_after got %b want 00", {err_timeout, busy}); end
    eng_en = 1'b1;
  endtask

  task automatic test_done_at_timeout();
    int n, errs;
    eng_lat = 63;
    req_x[W-1:0] = W'(10000); req_y[W-1:0] = W'(5000);
    req = 3'b001;
    wait_evt(0, 5, n);
    req = '0;
    n = -1; errs = 0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (err_timeout) errs++;
      if (rsp_valid == 3'b001 && n < 0) n = i;
    end
    n_checks++; if (n !== 64) begin n_errors++; $display("FAIL tie_rsp got %0d want 64", n); end
    n_checks++; if (errs !== 0) begin n_errors++; $display("FAIL tie_no_err got %0d want 0", errs); end
    n_checks++; if (rsp_angle !== W'(15000) || rsp_magnitude !== W'(5000)) begin n_errors++; $display("FAIL tie_result got %0d,%0d want 15000,5000", rsp_angle, rsp_magnitude); end
  endtask

  task automatic test_reset_mid_wait();
    int n, rv, bz;
    eng_lat = 20;
    req_x[W-1:0] = W'(7); req_y[W-1:0] = W'(2);
    req = 3'b001;
    wait_evt(0, 5, n);
    req = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({gnt, rsp_valid, crd_start, err_timeout, busy} !== '0) begin n_errors++; $display("FAIL midreset_ctrl got %b want 0", {gnt, rsp_valid, crd_start, err_timeout, busy}); end
    n_checks++; if ({crd_x, crd_y, rsp_angle, rsp_magnitude} !== '0) begin n_errors++; $display("FAIL midreset_data got %h want 0", {crd_x, crd_y, rsp_angle, rsp_magnitude}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rv = 0; bz = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) rv++;
      if (busy) bz++;
    end
    n_checks++; if (rv !== 0 || bz !== 0) begin n_errors++; $display("FAIL midreset_stale got rsp=%0d busy=%0d want 0,0", rv, bz); end
    req_x[W-1:0] = W'(3); req_y[W-1:0] = W'(1);
    req = 3'b011;
    wait_evt(0, 5, n);
    n_checks++; if (n !== 1 || gnt !== 3'b001) begin n_errors++; $display("FAIL midreset_regrant got n=%0d gnt=%b want n=1 gnt=001", n, gnt); end
    req = '0;
    wait_evt(1, 30, n);
    n_checks++; if (n !== 21 || rsp_angle !== W'(4) || rsp_magnitude !== W'(2)) begin n_errors++; $display("FAIL midreset_result got n=%0d %0d,%0d want n=21 4,2", n, rsp_angle, rsp_magnitude); end
  endtask

  task automatic test_stray_done();
    int rv, bz;
    rv = 0; bz = 0;
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid != '0) rv++;
      if (busy) bz++;
      @(negedge clk);
    end
    n_checks++; if (rv !== 0 || bz !== 0) begin n_errors++; $display("FAIL stray_state got rsp=%0d busy=%0d want 0,0", rv, bz); end
    n_checks++; if (rsp_angle !== W'(4) || rsp_magnitude !== W'(2)) begin n_errors++; $display("FAIL stray_hold got %0d,%0d want 4,2", rsp_angle, rsp_magnitude); end
  endtask

  initial begin
    req = '0; req_x = '0; req_y = '0;
    stray_done = 1'b0; eng_en = 1'b1; eng_lat = 20;
    test_reset();
    test_single();
    do_reset();
    test_contention();
    test_fairness();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid_wait();
    test_stray_done();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
